// File: rtl/jtkiwi_gfxrom_arb.sv
// jtkiwi_gfxrom_arb
// Shares the single SDRAM graphics-ROM slot between the scroll tile fetcher
// (scr_*) and the object fetcher (obj_*). Each requester has a one-entry
// 32-bit word cache. A hit answers combinationally. A miss is sequenced through
// the SDRAM slot with round-robin arbitration when both ports miss together.
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   flush          invalidates both caches; also discards an in-flight read
//   scr_cs/addr    scroll request and 32-bit word address [19:2]
//   scr_data/ok    cached scroll word; ok = cs & hit for the current address
//   obj_*          same for the object port
//   rom_cs/addr    SDRAM request and word address (registered)
//   rom_data/ok    SDRAM read data and data-valid strobe
//   tout           sticky timeout flag, cleared only by rst
module jtkiwi_gfxrom_arb #(
  parameter logic [7:0] TOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,

  input  logic        scr_cs,
  input  logic [19:2] scr_addr,
  output logic [31:0] scr_data,
  output logic        scr_ok,

  input  logic        obj_cs,
  input  logic [19:2] obj_addr,
  output logic [31:0] obj_data,
  output logic        obj_ok,

  output logic        rom_cs,
  output logic [19:2] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        rom_ok,

  output logic        tout
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_GAP
  } state_t;

  typedef enum logic {
    PORT_SCR,
    PORT_OBJ
  } port_t;

  state_t      state, state_nxt;
  port_t       gnt, last, gnt_sel;

  logic [19:2] scr_caddr, obj_caddr;
  logic [31:0] scr_cdata, obj_cdata;
  logic        scr_cvalid, obj_cvalid;

  logic [7:0]  cnt;
  logic        armed;   // low during the first WAIT cycle, when rom_ok may be stale
  logic        drop;    // set by flush in WAIT: in-flight result must not be cached

  logic        scr_hit, obj_hit;
  logic        scr_pend, obj_pend;

  logic        grant_en;
  logic        done;    // accepted rom_ok
  logic        abort;   // timeout
  logic        fill;
  logic        cnt_inc;

  assign scr_hit  = scr_cvalid && (scr_addr == scr_caddr);
  assign obj_hit  = obj_cvalid && (obj_addr == obj_caddr);
  assign scr_pend = scr_cs && !scr_hit;
  assign obj_pend = obj_cs && !obj_hit;

  assign scr_ok   = scr_cs && scr_hit;
  assign obj_ok   = obj_cs && obj_hit;
  assign scr_data = scr_cdata;
  assign obj_data = obj_cdata;

  // Next-state and control strobes
  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    gnt_sel   = PORT_SCR;
    done      = 1'b0;
    abort     = 1'b0;
    fill      = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (scr_pend && obj_pend) begin
          gnt_sel  = (last == PORT_OBJ) ? PORT_SCR : PORT_OBJ;
          grant_en = 1'b1;
        end else if (scr_pend) begin
          gnt_sel  = PORT_SCR;
          grant_en = 1'b1;
        end else if (obj_pend) begin
          gnt_sel  = PORT_OBJ;
          grant_en = 1'b1;
        end
        if (grant_en) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (armed && rom_ok) begin
          done      = 1'b1;
          // a flush in this very cycle also discards the result
          fill      = !(drop || flush);
          state_nxt = ST_GAP;
        end else if (cnt == TOUT) begin
          abort     = 1'b1;
          state_nxt = ST_GAP;
        end else begin
          cnt_inc   = 1'b1;
        end
      end
      ST_GAP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Datapath, caches and SDRAM request
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_cs     <= 1'b0;
      rom_addr   <= '0;
      gnt        <= PORT_SCR;
      last       <= PORT_OBJ;
      cnt        <= '0;
      armed      <= 1'b0;
      drop       <= 1'b0;
      tout       <= 1'b0;
      scr_caddr  <= '0;
      scr_cdata  <= '0;
      scr_cvalid <= 1'b0;
      obj_caddr  <= '0;
      obj_cdata  <= '0;
      obj_cvalid <= 1'b0;
    end else begin
      if (grant_en) begin
        rom_addr <= (gnt_sel == PORT_OBJ) ? obj_addr : scr_addr;
        rom_cs   <= 1'b1;
        gnt      <= gnt_sel;
        cnt      <= '0;
        armed    <= 1'b0;
      end

      if (state == ST_WAIT) armed <= 1'b1;
      if (cnt_inc)          cnt   <= cnt + 8'd1;

      if (fill) begin
        if (gnt == PORT_OBJ) begin
          obj_caddr  <= rom_addr;
          obj_cdata  <= rom_data;
          obj_cvalid <= 1'b1;
        end else begin
          scr_caddr  <= rom_addr;
          scr_cdata  <= rom_data;
          scr_cvalid <= 1'b1;
        end
      end

      if (flush) begin
        scr_cvalid <= 1'b0;
        obj_cvalid <= 1'b0;
        if (state == ST_WAIT) drop <= 1'b1;
      end

      // Entering GAP ends the access; this also overrides a same-cycle drop set
      if (done || abort) begin
        rom_cs <= 1'b0;
        last   <= gnt;
        drop   <= 1'b0;
      end

      if (abort) tout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtkiwi_gfxrom_arb.sv
module tb_jtkiwi_gfxrom_arb;

  localparam logic [7:0] TOUT_TB = 8'd8;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        scr_cs, obj_cs;
  logic [19:2] scr_addr, obj_addr;
  logic [31:0] scr_data, obj_data;
  logic        scr_ok, obj_ok;
  logic        rom_cs, rom_ok, tout;
  logic [19:2] rom_addr;
  logic [31:0] rom_data;

  always #5 clk = ~clk;

  jtkiwi_gfxrom_arb #(.TOUT(TOUT_TB)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .scr_cs   (scr_cs),
    .scr_addr (scr_addr),
    .scr_data (scr_data),
    .scr_ok   (scr_ok),
    .obj_cs   (obj_cs),
    .obj_addr (obj_addr),
    .obj_data (obj_data),
    .obj_ok   (obj_ok),
    .rom_cs   (rom_cs),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rom_ok   (rom_ok),
    .tout     (tout)
  );

  typedef struct {
    logic        rst, fl, scs;
    logic [19:2] sa;
    logic        ocs;
    logic [19:2] oa;
    logic        rok;
    logic [31:0] rd;
    logic        e_cs;
    logic [19:2] e_addr;
    logic        e_sok;
    logic [31:0] e_sdata;
    logic        e_ook;
    logic [31:0] e_odata;
    logic        e_tout;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(
    input logic rst_i, input logic fl, input logic scs, input logic [19:2] sa,
    input logic ocs, input logic [19:2] oa, input logic rok, input logic [31:0] rd,
    input logic e_cs, input logic [19:2] e_addr, input logic e_sok, input logic [31:0] e_sdata,
    input logic e_ook, input logic [31:0] e_odata, input logic e_tout);
    vec_t v;
    v.rst = rst_i; v.fl = fl; v.scs = scs; v.sa = sa; v.ocs = ocs; v.oa = oa;
    v.rok = rok; v.rd = rd; v.e_cs = e_cs; v.e_addr = e_addr; v.e_sok = e_sok;
    v.e_sdata = e_sdata; v.e_ook = e_ook; v.e_odata = e_odata; v.e_tout = e_tout;
    return v;
  endfunction

  function automatic logic [31:0] mem(input logic [19:2] a);
    return {14'h2A5, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Polls once per cycle (negedge+1) until rom_cs is seen; leaves time at negedge+1.
  task automatic wait_rom_cs(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (rom_cs) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // Called in the first WAIT cycle: answers in the second WAIT cycle, returns at GAP negedge.
  task automatic serve(input logic [31:0] d);
    @(negedge clk);
    rom_ok   = 1'b1;
    rom_data = d;
    @(negedge clk);
    rom_ok   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int low, high;
    rst = 1'b1; flush = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
    scr_addr = '0; obj_addr = '0; rom_ok = 1'b0; rom_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ---------------- table: reset state, scroll miss then hits ----------------
    //            rst fl scs sa        ocs oa rok rd            cs addr      sok sdata         ook odata tout
    tbl.push_back(mk(0, 0, 0, 18'h0,     0, 0, 0, 0,            0, 18'h0,     0, 32'h0,         0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 18'h00100, 0, 0, 0, 0,            0, 18'h0,     0, 32'h0,         0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 18'h00100, 0, 0, 0, 0,            1, 18'h00100, 0, 32'h0,         0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 18'h00100, 0, 0, 0, 0,            1, 18'h00100, 0, 32'h0,         0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 18'h00100, 0, 0, 0, 0,            1, 18'h00100, 0, 32'h0,         0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 18'h00100, 0, 0, 1, 32'hDEADBEEF, 1, 18'h00100, 0, 32'h0,         0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 18'h00100, 0, 0, 0, 0,            0, 18'h00100, 1, 32'hDEADBEEF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 18'h00100, 0, 0, 0, 0,            0, 18'h00100, 1, 32'hDEADBEEF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 18'h00100, 0, 0, 0, 0,            0, 18'h00100, 1, 32'hDEADBEEF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 18'h00100, 0, 0, 0, 0,            0, 18'h00100, 0, 32'hDEADBEEF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 18'h00101, 0, 0, 0, 0,            0, 18'h00100, 0, 32'hDEADBEEF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 18'h00101, 0, 0, 0, 0,            1, 18'h00101, 0, 32'hDEADBEEF, 0, 0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; flush = tbl[i].fl; scr_cs = tbl[i].scs; scr_addr = tbl[i].sa;
      obj_cs = tbl[i].ocs; obj_addr = tbl[i].oa; rom_ok = tbl[i].rok; rom_data = tbl[i].rd;
      #1;
      check($sformatf("v%0d rom_cs", i),   32'(rom_cs),   32'(tbl[i].e_cs));
      check($sformatf("v%0d rom_addr", i), 32'(rom_addr), 32'(tbl[i].e_addr));
      check($sformatf("v%0d scr_ok", i),   32'(scr_ok),   32'(tbl[i].e_sok));
      check($sformatf("v%0d scr_data", i), scr_data,      tbl[i].e_sdata);
      check($sformatf("v%0d obj_ok", i),   32'(obj_ok),   32'(tbl[i].e_ook));
      check($sformatf("v%0d obj_data", i), obj_data,      tbl[i].e_odata);
      check($sformatf("v%0d tout", i),     32'(tout),     32'(tbl[i].e_tout));
    end

    // ---------------- round robin after reset ----------------
    @(negedge clk); rst = 1'b1; scr_cs = 1'b0; obj_cs = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      scr_cs = 1'b1; scr_addr = 18'h00010 + 18'(r);
      obj_cs = 1'b1; obj_addr = 18'h20000 + 18'(r);
      wait_rom_cs($sformatf("rr%0d first grant", r));
      check($sformatf("rr%0d first addr", r), 32'(rom_addr), 32'(18'h00010 + 18'(r)));
      serve(mem(rom_addr));
      wait_rom_cs($sformatf("rr%0d second grant", r));
      check($sformatf("rr%0d second addr", r), 32'(rom_addr), 32'(18'h20000 + 18'(r)));
      serve(mem(rom_addr));
      #1;
      check($sformatf("rr%0d scr_ok", r),   32'(scr_ok), 32'd1);
      check($sformatf("rr%0d obj_ok", r),   32'(obj_ok), 32'd1);
      check($sformatf("rr%0d scr_data", r), scr_data, mem(18'h00010 + 18'(r)));
      check($sformatf("rr%0d obj_data", r), obj_data, mem(18'h20000 + 18'(r)));
    end
    // scr served alone, then a tie: obj must win
    @(negedge clk); obj_cs = 1'b0; scr_addr = 18'h00300;
    wait_rom_cs("solo scr grant");
    serve(mem(rom_addr));
    @(negedge clk); scr_addr = 18'h00301; obj_cs = 1'b1; obj_addr = 18'h20300;
    wait_rom_cs("tie after scr grant");
    check("tie after scr addr", 32'(rom_addr), 32'(18'h20300));
    serve(mem(rom_addr));
    wait_rom_cs("tie second grant");
    check("tie second addr", 32'(rom_addr), 32'(18'h00301));
    serve(mem(rom_addr));

    // ---------------- rom_ok held high ----------------
    @(negedge clk); scr_cs = 1'b0; obj_cs = 1'b0; rom_ok = 1'b1; rom_data = 32'h11112222;
    @(negedge clk); scr_cs = 1'b1; scr_addr = 18'h00400;
    wait_rom_cs("hold grant");
    check("hold w1 scr_ok", 32'(scr_ok), 32'd0);
    @(negedge clk); #1;
    check("hold w2 rom_cs", 32'(rom_cs), 32'd1);
    check("hold w2 scr_ok", 32'(scr_ok), 32'd0);
    @(negedge clk); obj_cs = 1'b1; obj_addr = 18'h00500; #1;
    check("hold gap rom_cs", 32'(rom_cs), 32'd0);
    check("hold scr_ok", 32'(scr_ok), 32'd1);
    check("hold scr_data", scr_data, 32'h11112222);
    low = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (rom_cs) break;
      low++;
    end
    check("hold gap >=2", 32'(low >= 2 && rom_cs), 32'd1);
    @(negedge clk); #1;
    check("hold obj w2 rom_cs", 32'(rom_cs), 32'd1);
    @(negedge clk); #1;
    check("hold obj_ok", 32'(obj_ok), 32'd1);
    rom_ok = 1'b0;

    // ---------------- flush during WAIT ----------------
    @(negedge clk); scr_cs = 1'b0; obj_addr = 18'h00200;
    wait_rom_cs("flush grant");
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; rom_ok = 1'b1; rom_data = 32'hAAAA0001;
    @(negedge clk); rom_ok = 1'b0; #1;
    check("flush gap obj_ok", 32'(obj_ok), 32'd0);
    wait_rom_cs("flush reissue");
    check("flush reissue addr", 32'(rom_addr), 32'(18'h00200));
    serve(32'hBBBB0002);
    #1;
    check("flush obj_ok", 32'(obj_ok), 32'd1);
    check("flush obj_data", obj_data, 32'hBBBB0002);

    // ---------------- timeout, then the other port ----------------
    @(negedge clk); scr_cs = 1'b1; scr_addr = 18'h00600; obj_addr = 18'h00700;
    wait_rom_cs("to grant");
    check("to first addr", 32'(rom_addr), 32'(18'h00600));
    high = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (!rom_cs) break;
      high++;
    end
    check("to wait cycles", 32'(high), 32'(TOUT_TB) + 32'd1);
    check("to flag", 32'(tout), 32'd1);
    check("to scr_ok", 32'(scr_ok), 32'd0);
    wait_rom_cs("to other grant");
    check("to other addr", 32'(rom_addr), 32'(18'h00700));
    serve(mem(rom_addr));
    #1;
    check("to obj_ok", 32'(obj_ok), 32'd1);
    check("to flag sticky", 32'(tout), 32'd1);

    // ---------------- reset in WAIT with rom_ok ----------------
    wait_rom_cs("rst grant");
    check("rst grant addr", 32'(rom_addr), 32'(18'h00600));
    @(negedge clk); rst = 1'b1; rom_ok = 1'b1; rom_data = 32'hCAFEF00D;
    @(negedge clk); rst = 1'b0; rom_ok = 1'b0; #1;
    check("rst rom_cs", 32'(rom_cs), 32'd0);
    check("rst rom_addr", 32'(rom_addr), 32'd0);
    check("rst tout", 32'(tout), 32'd0);
    check("rst scr_ok", 32'(scr_ok), 32'd0);
    check("rst scr_data", scr_data, 32'd0);
    check("rst obj_ok", 32'(obj_ok), 32'd0);
    check("rst obj_data", obj_data, 32'd0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
